scoreboard: RTL

SCOREBOARD -- requirements
Module: scoreboard

---
 rtl/rv32i_types.sv | 14 +
 rtl/scoreboard_if.sv | 42 ++++
 rtl/scoreboard.sv | 100 ++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I types.
// Purpose: register-index type used across the pipeline plus the scoreboard
// pending-count default width and count type.
// Ports: none (package).
package rv32i_types;

    typedef logic [4:0] rv32i_reg;

    // Default width of each per-register scoreboard pending counter.
    localparam int unsigned SB_CNT_W = 2;

    typedef logic [SB_CNT_W-1:0] sb_cnt_t;

endpackage

// File: rtl/scoreboard_if.sv
// Scoreboard bus interface.
// Purpose: bundles the ID-stage query, WB-stage retire and status signals of
// the register scoreboard.
// Modports:
//   master - pipeline side: drives ID/WB signals, observes stall/busy/count.
//   slave  - scoreboard side: the reverse.
// Signals:
//   rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID  source operands of the ID instruction
//   rd_ID, load_regfile_ID, long_lat_ID       destination of the ID instruction
//   advance_ID                                ID->EX transfer this cycle
//   rd_WB, commit_WB                          long-latency write committing in WB
//   stall_ID, busy, stall_cycles              scoreboard outputs
interface scoreboard_if;
    import rv32i_types::*;

    rv32i_reg    rs1_ID;
    rv32i_reg    rs2_ID;
    logic        rs1_used_ID;
    logic        rs2_used_ID;
    rv32i_reg    rd_ID;
    logic        load_regfile_ID;
    logic        long_lat_ID;
    logic        advance_ID;
    rv32i_reg    rd_WB;
    logic        commit_WB;
    logic        stall_ID;
    logic        busy;
    logic [31:0] stall_cycles;

    modport master (
        output rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID, rd_ID, load_regfile_ID,
        output long_lat_ID, advance_ID, rd_WB, commit_WB,
        input  stall_ID, busy, stall_cycles
    );

    modport slave (
        input  rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID, rd_ID, load_regfile_ID,
        input  long_lat_ID, advance_ID, rd_WB, commit_WB,
        output stall_ID, busy, stall_cycles
    );

endinterface

// File: rtl/scoreboard.sv
// Register scoreboard for long-latency results (loads, mul/div).
// Purpose: tracks, per architectural register x1..x31, how many in-flight
// long-latency writes are pending, and stalls ID when an operand is still
// pending or when a destination counter would overflow.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - synchronous active-high reset
//   bus  - scoreboard_if.slave (ID query, WB retire, stall/busy/stall_cycles)
// Parameters:
//   CNT_W - width of each pending counter
module scoreboard
    import rv32i_types::*;
#(
    parameter int unsigned CNT_W = SB_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    scoreboard_if.slave  bus
);

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [CNT_W-1:0] w_cnt [32];
    logic             w_retire;
    logic             w_cand;
    logic             w_haz1;
    logic             w_haz2;
    logic             w_full;
    logic             w_stall;
    logic             w_issue;
    logic             w_busy;
    logic [31:0]      r_stall_cycles;

    // x0 has no counter and never stalls.
    assign w_cnt[0] = '0;

    assign w_retire = bus.commit_WB & (bus.rd_WB != '0);
    assign w_cand   = bus.load_regfile_ID & bus.long_lat_ID & (bus.rd_ID != '0);

    // A retire of the last pending write this cycle is covered by the WB->ID
    // regfile bypass, so the effective count is cnt minus that retire.
    assign w_haz1 = bus.rs1_used_ID && (bus.rs1_ID != '0) && (w_cnt[bus.rs1_ID] != '0) &&
                    !(w_retire && (bus.rd_WB == bus.rs1_ID) && (w_cnt[bus.rs1_ID] == CntOne));
    assign w_haz2 = bus.rs2_used_ID && (bus.rs2_ID != '0) && (w_cnt[bus.rs2_ID] != '0) &&
                    !(w_retire && (bus.rd_WB == bus.rs2_ID) && (w_cnt[bus.rs2_ID] == CntOne));

    // Saturated destination counter: only safe if a retire frees a slot now.
    assign w_full = w_cand && (w_cnt[bus.rd_ID] == CntMax) &&
                    !(w_retire && (bus.rd_WB == bus.rd_ID));

    assign w_stall = ~rst & (w_haz1 | w_haz2 | w_full);
    assign w_issue = bus.advance_ID & ~w_stall & w_cand;

    for (genvar g = 1; g < 32; g++) begin : g_cnt
        logic [CNT_W-1:0] r_cnt;
        logic             w_inc;
        logic             w_dec;

        assign w_inc = w_issue & (bus.rd_ID == rv32i_reg'(g));
        // Retire at zero is a protocol error; ignore it rather than wrap.
        assign w_dec = w_retire & (bus.rd_WB == rv32i_reg'(g)) & (r_cnt != '0);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (w_inc && !w_dec) begin
                r_cnt <= r_cnt + CntOne;
            end else if (w_dec && !w_inc) begin
                r_cnt <= r_cnt - CntOne;
            end
        end

        assign w_cnt[g] = r_cnt;
    end

    always_comb begin
        w_busy = 1'b0;
        for (int i = 1; i < 32; i++) begin
            w_busy = w_busy | (w_cnt[i] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (w_stall) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign bus.stall_ID     = w_stall;
    assign bus.busy         = w_busy;
    assign bus.stall_cycles = r_stall_cycles;

    a_retire_pending: assert property (@(posedge clk) disable iff (rst)
        !(w_retire && (w_cnt[bus.rd_WB] == '0)))
        else $error("scoreboard: retire of register x%0d with no pending write", bus.rd_WB);

endmodule
